// File: rtl/elastic_config_loader_pkg.sv
// Shared types and constants for the elastic PE configuration loader.
// Holds the ElasticConfigData layout, context/operand widths and FSM state codes.
// No logic here; every other file imports this package.
package elastic_config_loader_pkg;

    localparam int CONTEXT_SIZE_BIT_LENGTH = 4;
    localparam int NEIGHBOR_PE_NUM         = 4;
    localparam int NEIGHBOR_ID_WIDTH       = $clog2(NEIGHBOR_PE_NUM);
    localparam int OPERATION_BIT_LENGTH    = 4;
    localparam int DATA_WIDTH              = 16;

    // Per-PE configuration payload broadcast to every ElasticPE.
    typedef struct packed {
        logic [NEIGHBOR_ID_WIDTH-1:0]    input_pe_index_1;
        logic [NEIGHBOR_ID_WIDTH-1:0]    input_pe_index_2;
        logic [NEIGHBOR_ID_WIDTH-1:0]    output_pe_index;
        logic [OPERATION_BIT_LENGTH-1:0] op;
        logic [DATA_WIDTH-1:0]           const_data;
    } ElasticConfigData;

    // cfg_data minus the pe_id field: {context_index, config fields, last}
    localparam int CFG_DATA_BASE_WIDTH = CONTEXT_SIZE_BIT_LENGTH + $bits(ElasticConfigData) + 1;

    // Loader FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

endpackage

// File: rtl/elastic_config_loader_if.sv
// Configuration word stream into the loader: {pe_id, context_index, fields, last}.
// Latency: none, wires only.
// Backpressure: cfg_stop_input high means the receiver will not take the word.
interface elastic_config_loader_if
    import elastic_config_loader_pkg::*;
#(
    parameter int PE_ID_WIDTH = 4
);

    logic [PE_ID_WIDTH+CFG_DATA_BASE_WIDTH-1:0] cfg_data;
    logic                                       cfg_valid_input;
    logic                                       cfg_stop_input;

    modport master (
        output cfg_data,
        output cfg_valid_input,
        input  cfg_stop_input
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid_input,
        output cfg_stop_input
    );

endinterface

// File: rtl/elastic_config_loader.sv
// Streams configuration words into ElasticPEs, then pulses start_exec (optional counter: ELASTIC_CONFIG_LOADER_COUNT_EN).
// Latency: accepted word -> one-hot strobe + broadcast fields 1 cycle later; start_exec 1 cycle after last strobe.
// Backpressure: cfg_stop_input low only in LOAD; one word per cycle accepted there, never stalls mid-load.
module elastic_config_loader
    import elastic_config_loader_pkg::*;
#(
    parameter int PE_NUM      = 16,
    parameter int PE_ID_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               load_request,
    input  logic                               abort,
    elastic_config_loader_if.slave             cfg,
    output logic [PE_NUM-1:0]                  write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [NEIGHBOR_ID_WIDTH-1:0]       config_input_PE_index_1,
    output logic [NEIGHBOR_ID_WIDTH-1:0]       config_input_PE_index_2,
    output logic [NEIGHBOR_ID_WIDTH-1:0]       config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               busy,
    output logic                               error
`ifdef ELASTIC_CONFIG_LOADER_COUNT_EN
    ,
    output logic [15:0]                        cfg_word_count
`endif
);

    logic [1:0]                         state;
    logic [1:0]                         state_nxt;
    logic [PE_ID_WIDTH-1:0]             word_pe_id;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] word_ctx;
    ElasticConfigData                   word_fields;
    logic                               word_last;
    logic [PE_NUM-1:0]                  pe_onehot;
    logic                               pe_valid;
    logic                               take;
    logic                               enter_load;

    assign {word_pe_id, word_ctx, word_fields, word_last} = cfg.cfg_data;

    assign cfg.cfg_stop_input = (state != ST_LOAD);
    assign busy               = (state == ST_LOAD) || (state == ST_START);

    // An abort in the acceptance cycle discards the word entirely.
    assign take       = (state == ST_LOAD) && cfg.cfg_valid_input && !abort;
    assign enter_load = !abort && load_request && ((state == ST_IDLE) || (state == ST_RUN));

    // Decode pe_id to a one-hot strobe; out-of-range ids decode to all zeros.
    always_comb begin
        pe_onehot = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            if (word_pe_id == PE_ID_WIDTH'(i)) begin
                pe_onehot[i] = 1'b1;
            end
        end
    end

    assign pe_valid = |pe_onehot;

    // Next-state logic; abort overrides everything, load_request ignored in LOAD/START.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: if (load_request) state_nxt = ST_LOAD;
                ST_LOAD:         if (take && word_last) state_nxt = ST_START;
                ST_START:        state_nxt = ST_RUN;
                default:         state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register plus one-cycle strobe and start pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            write_config_data <= '0;
            start_exec        <= 1'b0;
        end else begin
            state             <= state_nxt;
            write_config_data <= take ? pe_onehot : '0;
            start_exec        <= (state == ST_START) && !abort;
        end
    end

    // Broadcast fields follow the most recently accepted word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            config_index            <= '0;
            config_input_PE_index_1 <= '0;
            config_input_PE_index_2 <= '0;
            config_output_PE_index  <= '0;
            config_op               <= '0;
            config_const_data       <= '0;
        end else if (take) begin
            config_index            <= word_ctx;
            config_input_PE_index_1 <= word_fields.input_pe_index_1;
            config_input_PE_index_2 <= word_fields.input_pe_index_2;
            config_output_PE_index  <= word_fields.output_pe_index;
            config_op               <= word_fields.op;
            config_const_data       <= word_fields.const_data;
        end
    end

    // Sticky error and max context id; both restart on every entry into LOAD, reconfiguration included.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            error                  <= 1'b0;
            mapping_context_max_id <= '0;
        end else if (enter_load) begin
            error                  <= 1'b0;
            mapping_context_max_id <= '0;
        end else if (take) begin
            if (!pe_valid) begin
                error <= 1'b1;
            end else if (word_ctx > mapping_context_max_id) begin
                mapping_context_max_id <= word_ctx;
            end
        end
    end

`ifdef ELASTIC_CONFIG_LOADER_COUNT_EN
    // Saturating count of strobes issued since the most recent entry into LOAD.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg_word_count <= '0;
        end else if (enter_load) begin
            cfg_word_count <= '0;
        end else if ((|write_config_data) && (cfg_word_count != 16'hFFFF)) begin
            cfg_word_count <= cfg_word_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_elastic_config_loader.sv
// Self-checking bench: two loaders (PE_NUM 16 and 8) share one stimulus stream.
// Latency: outputs sampled 1 ns after each rising edge against a behavioural model.
// Backpressure: the model predicts cfg_stop_input; stimulus never depends on DUT outputs.
`timescale 1ns/1ps
module tb_elastic_config_loader;
    import elastic_config_loader_pkg::*;

    localparam int NFIELD = $bits(ElasticConfigData);
    localparam int OBS_W  = 16 + 4 + 2*CONTEXT_SIZE_BIT_LENGTH + NFIELD + 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic             load_request;
    logic             abort;
    logic [3:0]       w_pe;
    logic [3:0]       w_ctx;
    ElasticConfigData w_fld;
    logic             w_last;
    logic             w_vld;

    elastic_config_loader_if #(.PE_ID_WIDTH(4)) bus16 ();
    elastic_config_loader_if #(.PE_ID_WIDTH(4)) bus8 ();

    assign bus16.cfg_data        = {w_pe, w_ctx, w_fld, w_last};
    assign bus16.cfg_valid_input = w_vld;
    assign bus8.cfg_data         = {w_pe, w_ctx, w_fld, w_last};
    assign bus8.cfg_valid_input  = w_vld;

    logic [15:0] wcd16;
    logic [7:0]  wcd8;
    logic [3:0]  idx16, idx8, max16, max8;
    logic [1:0]  a16, b16, o16, a8, b8, o8;
    logic [3:0]  op16, op8;
    logic [15:0] cd16, cd8;
    logic        start16, start8, busy16, busy8, err16, err8;
    logic [15:0] cnt16, cnt8;

    elastic_config_loader #(.PE_NUM(16), .PE_ID_WIDTH(4)) dut16 (
        .clk(clk), .reset_n(reset_n), .load_request(load_request), .abort(abort),
        .cfg(bus16.slave), .write_config_data(wcd16), .config_index(idx16),
        .config_input_PE_index_1(a16), .config_input_PE_index_2(b16),
        .config_output_PE_index(o16), .config_op(op16), .config_const_data(cd16),
        .start_exec(start16), .mapping_context_max_id(max16), .busy(busy16), .error(err16)
`ifdef ELASTIC_CONFIG_LOADER_COUNT_EN
        , .cfg_word_count(cnt16)
`endif
    );

    elastic_config_loader #(.PE_NUM(8), .PE_ID_WIDTH(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .load_request(load_request), .abort(abort),
        .cfg(bus8.slave), .write_config_data(wcd8), .config_index(idx8),
        .config_input_PE_index_1(a8), .config_input_PE_index_2(b8),
        .config_output_PE_index(o8), .config_op(op8), .config_const_data(cd8),
        .start_exec(start8), .mapping_context_max_id(max8), .busy(busy8), .error(err8)
`ifdef ELASTIC_CONFIG_LOADER_COUNT_EN
        , .cfg_word_count(cnt8)
`endif
    );

`ifndef ELASTIC_CONFIG_LOADER_COUNT_EN
    assign cnt16 = 16'h0;
    assign cnt8  = 16'h0;
`endif

    // Observed outputs: {strobe, start, error, busy, stop, max_id, index, fields, count}
    logic [OBS_W-1:0] obs [2];
    assign obs[0] = {wcd16, start16, err16, busy16, bus16.cfg_stop_input, max16, idx16,
                     a16, b16, o16, op16, cd16, cnt16};
    assign obs[1] = {8'h00, wcd8, start8, err8, busy8, bus8.cfg_stop_input, max8, idx8,
                     a8, b8, o8, op8, cd8, cnt8};

    // Behavioural reference: which phase the loader is in, and what it has produced.
    int               pe_num [2] = '{16, 8};
    bit               m_loading [2];
    bit               m_final [2];
    bit               m_running [2];
    logic [15:0]      m_strobe [2];
    bit               m_start [2];
    bit               m_err [2];
    logic [3:0]       m_max [2];
    logic [3:0]       m_idx [2];
    ElasticConfigData m_fld [2];
    int               m_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [OBS_W-1:0] model_obs(int d);
        logic [15:0] cnt;
`ifdef ELASTIC_CONFIG_LOADER_COUNT_EN
        cnt = 16'(m_cnt[d]);
`else
        cnt = 16'h0;
`endif
        return {m_strobe[d], m_start[d], m_err[d], m_loading[d] | m_final[d], !m_loading[d],
                m_max[d], m_idx[d], m_fld[d], cnt};
    endfunction

    // Advance the model by one clock using the inputs now on the pins, then clock the DUTs.
    task automatic tick();
        bit take, in_range, idle;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_loading[d] = 0; m_final[d] = 0; m_running[d] = 0;
                m_strobe[d] = '0; m_start[d] = 0; m_err[d] = 0;
                m_max[d] = '0; m_idx[d] = '0; m_fld[d] = '0; m_cnt[d] = 0;
            end else begin
                in_range = int'(w_pe) < pe_num[d];
                take     = m_loading[d] && w_vld && !abort;
                idle     = !m_loading[d] && !m_final[d] && !m_running[d];
                if (m_strobe[d] != 0 && m_cnt[d] < 65535) m_cnt[d]++;
                m_start[d]  = m_final[d] && !abort;
                m_strobe[d] = (take && in_range) ? (16'(1) << w_pe) : 16'h0;
                if (take) begin
                    m_idx[d] = w_ctx;
                    m_fld[d] = w_fld;
                    if (!in_range) m_err[d] = 1;
                    else if (w_ctx > m_max[d]) m_max[d] = w_ctx;
                end
                if (abort) begin
                    m_loading[d] = 0; m_final[d] = 0; m_running[d] = 0;
                end else if (load_request && (idle || m_running[d])) begin
                    m_loading[d] = 1; m_running[d] = 0;
                    m_err[d] = 0; m_max[d] = '0; m_cnt[d] = 0;
                end else if (take && w_last) begin
                    m_loading[d] = 0; m_final[d] = 1;
                end else if (m_final[d]) begin
                    m_final[d] = 0; m_running[d] = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [3:0] pe, input logic [3:0] ctx, input logic last);
        logic [31:0] r;
        r      = $urandom;
        w_pe   = pe;
        w_ctx  = ctx;
        w_fld  = r[NFIELD-1:0];
        w_last = last;
        w_vld  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_request = 1'b0; abort = 1'b0;
        w_vld = 1'b0; w_pe = '0; w_ctx = '0; w_fld = '0; w_last = 1'b0;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== model_obs(d)) begin
                n_fail++;
                $display("FAIL reset_model dut%0d got=%h want=%h", pe_num[d], obs[d], model_obs(d));
            end
        end
        n_checks++;
        if ({wcd16, start16, err16, busy16, max16, bus16.cfg_stop_input} !== {16'h0, 3'b000, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values got strobe=%h start=%b err=%b busy=%b max=%h stop=%b want 0/0/0/0/0/1",
                     wcd16, start16, err16, busy16, max16, bus16.cfg_stop_input);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_three_words();
        logic [15:0] want_strobe [3];
        want_strobe[0] = 16'h0001; want_strobe[1] = 16'h0020; want_strobe[2] = 16'h8000;
        load_request = 1'b1; tick(); load_request = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) set_word(4'd0, 4'd0, 1'b0);
            else if (k == 1) set_word(4'd5, 4'd2, 1'b0);
            else if (k == 2) set_word(4'd15, 4'd1, 1'b1);
            else w_vld = 1'b0;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== model_obs(d)) begin
                    n_fail++;
                    $display("FAIL three_words_model dut%0d step%0d got=%h want=%h", pe_num[d], k, obs[d], model_obs(d));
                end
            end
            if (k < 3) begin
                n_checks++;
                if (wcd16 !== want_strobe[k]) begin
                    n_fail++;
                    $display("FAIL three_words_strobe step%0d got=%h want=%h", k, wcd16, want_strobe[k]);
                end
            end
        end
        // k==3 was the start_exec cycle; now settled in RUN
        n_checks++;
        if ({max16, start16, busy16, bus16.cfg_stop_input, err8} !== {4'd2, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL three_words_final got max=%h start=%b busy=%b stop=%b err8=%b want 2/0/0/1/1",
                     max16, start16, busy16, bus16.cfg_stop_input, err8);
        end
    endtask

    task automatic test_gaps();
        int n_words, seen, accepted;
        for (int round = 0; round < 4; round++) begin
            n_words = 3 + int'($urandom_range(0, 4));
            seen = 0; accepted = 0;
            load_request = 1'b1; w_vld = 1'b0; tick(); load_request = 1'b0;
            for (int c = 0; c < 60; c++) begin
                if (accepted < n_words && ($urandom % 3) != 0) begin
                    set_word(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), accepted == n_words - 1);
                    accepted++;
                end else begin
                    w_vld = 1'b0;
                end
                tick();
                if (wcd16 != 16'h0) seen++;
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (obs[d] !== model_obs(d)) begin
                        n_fail++;
                        $display("FAIL gaps_model dut%0d round%0d cyc%0d got=%h want=%h", pe_num[d], round, c, obs[d], model_obs(d));
                    end
                end
            end
            n_checks++;
            if (seen != n_words) begin
                n_fail++;
                $display("FAIL gaps_strobe_count round%0d got=%0d want=%0d", round, seen, n_words);
            end
        end
    endtask

    task automatic test_bad_pe();
        load_request = 1'b1; w_vld = 1'b0; tick(); load_request = 1'b0;
        set_word(4'd15, 4'd3, 1'b0); tick();
        n_checks++;
        if ({wcd8, err8, wcd16, err16} !== {8'h00, 1'b1, 16'h8000, 1'b0}) begin
            n_fail++;
            $display("FAIL bad_pe_detect got wcd8=%h err8=%b wcd16=%h err16=%b want 00/1/8000/0", wcd8, err8, wcd16, err16);
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 3) set_word(4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), k == 2);
            else w_vld = 1'b0;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== model_obs(d)) begin
                    n_fail++;
                    $display("FAIL bad_pe_model dut%0d step%0d got=%h want=%h", pe_num[d], k, obs[d], model_obs(d));
                end
            end
        end
        n_checks++;
        if (err8 !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_pe_sticky got=%b want=1", err8);
        end
        load_request = 1'b1; tick(); load_request = 1'b0;
        n_checks++;
        if ({err8, busy8} !== 2'b01) begin
            n_fail++;
            $display("FAIL bad_pe_clear got err8=%b busy8=%b want 0/1", err8, busy8);
        end
    endtask

    task automatic test_abort();
        // already in LOAD from the previous test
        set_word(4'd3, 4'd4, 1'b0); tick();
        set_word(4'd6, 4'd5, 1'b1); abort = 1'b1; tick(); abort = 1'b0; w_vld = 1'b0;
        n_checks++;
        if ({wcd16, busy16, bus16.cfg_stop_input, start16} !== {16'h0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_last got strobe=%h busy=%b stop=%b start=%b want 0/0/1/0",
                     wcd16, busy16, bus16.cfg_stop_input, start16);
        end
        tick();
        n_checks++;
        if ({start16, start8, busy16} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_no_start got start16=%b start8=%b busy=%b want 0/0/0", start16, start8, busy16);
        end
        // abort during the final-strobe cycle also cancels start_exec
        load_request = 1'b1; tick(); load_request = 1'b0;
        set_word(4'd2, 4'd1, 1'b1); tick(); w_vld = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== model_obs(d)) begin
                n_fail++;
                $display("FAIL abort_start_model dut%0d got=%h want=%h", pe_num[d], obs[d], model_obs(d));
            end
        end
        n_checks++;
        if ({start16, bus16.cfg_stop_input} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_start got start=%b stop=%b want 0/1", start16, bus16.cfg_stop_input);
        end
    endtask

    task automatic test_reset_mid_load();
        load_request = 1'b1; tick(); load_request = 1'b0;
        set_word(4'd4, 4'd6, 1'b0); tick();
        set_word(4'd7, 4'd9, 1'b0); reset_n = 1'b0; tick(); reset_n = 1'b1; w_vld = 1'b0;
        n_checks++;
        if ({wcd16, start16, err16, busy16, max16, idx16, cd16, bus16.cfg_stop_input} !==
            {16'h0, 3'b000, 1'b0, 4'h0, 4'h0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_load got strobe=%h max=%h idx=%h busy=%b stop=%b want all 0, stop 1",
                     wcd16, max16, idx16, busy16, bus16.cfg_stop_input);
        end
        load_request = 1'b1; tick(); load_request = 1'b0;
        set_word(4'd9, 4'd7, 1'b0); tick(); w_vld = 1'b0;
        n_checks++;
        if ({wcd16, max16} !== {16'h0200, 4'd7}) begin
            n_fail++;
            $display("FAIL reset_reload got strobe=%h max=%h want 0200/7", wcd16, max16);
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== model_obs(d)) begin
                n_fail++;
                $display("FAIL reset_reload_model dut%0d got=%h want=%h", pe_num[d], obs[d], model_obs(d));
            end
        end
    endtask

`ifdef ELASTIC_CONFIG_LOADER_COUNT_EN
    task automatic test_count();
        abort = 1'b1; tick(); abort = 1'b0;
        load_request = 1'b1; tick(); load_request = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_word(4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), k == 4);
            tick();
        end
        w_vld = 1'b0; tick(); tick();
        n_checks++;
        if ({cnt16, cnt8} !== {16'd5, 16'd5}) begin
            n_fail++;
            $display("FAIL count_five got cnt16=%0d cnt8=%0d want 5/5", cnt16, cnt8);
        end
        load_request = 1'b1; tick(); load_request = 1'b0;
        n_checks++;
        if ({cnt16, busy16} !== {16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL count_reload got cnt=%0d busy=%b want 0/1", cnt16, busy16);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            reset_n      = ($urandom % 150) != 0;
            load_request = ($urandom % 8) == 0;
            abort        = ($urandom % 40) == 0;
            set_word(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom % 6) == 0);
            w_vld        = ($urandom % 3) != 0;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== model_obs(d)) begin
                    n_fail++;
                    $display("FAIL random_model dut%0d cyc%0d got=%h want=%h", pe_num[d], c, obs[d], model_obs(d));
                end
            end
        end
        reset_n = 1'b1; load_request = 1'b0; abort = 1'b0; w_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_gaps();
        test_bad_pe();
        test_abort();
        test_reset_mid_load();
`ifdef ELASTIC_CONFIG_LOADER_COUNT_EN
        test_count();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
